ahbl2axi4l_p: RTL
=================

// Module: ahbl2axi4l_p
// PURPOSE
//  Parametrised AHB-Lite slave to AXI4-Lite master bridge.
//  Adds over the first generation: configurable address/data width, proper AHB two-cycle ERROR response,
//  hsel/hreadyin qualification, and optional posted writes with a bounded outstanding-B counter.
//  Sits between the CPU AHB-Lite fabric and AXI4-Lite peripheral interconnect.
// PARAMETERS
//  ADDR_W     32  address width, AHB and AXI
//  DATA_W     32  data width; 32 or 64 only (other values: elaboration $error)
//  POSTED_WR  0   0: AHB write completes on B; 1: completes on W handshake, B retired in background
//  MAX_WR_OUT 2   posted mode only: max writes issued but not yet answered by B (1..15)
// PORTS
//  aclk          in   1        clock, all logic on rising edge
//  areset        in   1        synchronous reset, active-high
//  ahb_hsel      in   1        slave select
//  ahb_hreadyin  in   1        fabric HREADY; address phase valid only when 1
//  ahb_haddr     in   ADDR_W   address
//  ahb_hsize     in   3        transfer size; 0..log2(DATA_W/8) legal
//  ahb_htrans    in   2        IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  ahb_hwrite    in   1        1=write
//  ahb_hwdata    in   DATA_W   write data (data phase)
//  ahb_hrdata    out  DATA_W   read data = axi_rdata
//  ahb_hready    out  1        HREADYOUT
//  ahb_hresp     out  1        0=OKAY 1=ERROR
//  axi_aw*/w*/b*/ar*/r*        AXI4-Lite master: awaddr/araddr ADDR_W, wdata/rdata DATA_W, wstrb DATA_W/8, bresp/rresp 2
//  wr_err        out  1        posted mode: sticky, set by any B with bresp[1]=1
//  wr_err_clr    in   1        clears wr_err; a same-cycle set wins
// BEHAVIOUR
//  Reset: FSM IDLE, hready=1, hresp=0, all AXI valids/readies 0, outstanding count 0, wr_err 0, addr/wstrb 0.
//  Accept: hsel & hreadyin & htrans[1] & hready in any state driving hready=1.
//   Latch addr, hwrite, wstrb; next state WR or RD.
//  wstrb: (2^(2^hsize))-1 shifted left by haddr[log2(DATA_W/8)-1:0]. Illegal hsize -> full strobe.
//  WR (data phase): hwdata is valid here, so AW and W are asserted together in the first WR cycle.
//   Independent done flags; each valid drops after its own handshake; no combinational path valid<-ready.
//   POSTED_WR=0: after both handshakes -> WRESP; bready=1; on bvalid: bresp[1] ? ERR1 : IDLE with hready=1.
//   POSTED_WR=1: hready=1 in the cycle the last of AW/W handshakes; count++ on that cycle.
//   bready=1 whenever count>0; count-- on B handshake; inc+dec same cycle -> unchanged.
//   New write accept stalls (hready held 0 in IDLE-wait) while count==MAX_WR_OUT.
//  RD: arvalid until arready; rready=1 throughout (R in same cycle as AR accepted).
//   On rvalid: rresp[1] ? ERR1 : IDLE with hready=1, hrdata=rdata that cycle.
//   In posted mode, arvalid is withheld until count==0 (read-after-write ordering).
//  ERR1: hready=0 hresp=1.  ERR2: hready=1 hresp=1. Next address phase is accepted normally in ERR2.
//   Master may drive IDLE there to cancel.
//  Back-to-back: completion cycle (hready=1) may accept next transfer; no idle cycle inserted.
//  BUSY/IDLE htrans while hready=1: no AXI activity, hresp=0.
//  Reset mid-transaction: all valids drop next cycle. Outstanding B count discarded. System resets AXI side together.
//  EXOKAY (2'b01) treated as OKAY.
// STRUCTURE
//  Package ahbl2axi4l_pkg: state enum {S_IDLE,S_WR,S_WRESP,S_RD,S_ERR1,S_ERR2}, HTRANS_* and AXI_RESP_* constants.
//  Sub-module ahbl_strb_gen (hsize, addr LSBs -> wstrb, parametrised by DATA_W), combinational.
//  Outstanding counter and wr_err in the top level.
// TESTING
//  1 DATA_W=32: NONSEQ write 0x100, hsize=0, haddr[1:0]=2 -> wstrb=4'b0100, wdata passed, hready low until bvalid.
//  2 DATA_W=64: read 0x08 with rresp=2'b10 -> hready0/hresp1 then hready1/hresp1, then OKAY on next read.
//  3 AW ready 3 cycles before W ready, and reverse -> each valid held until its own handshake, single AXI write.
//  4 POSTED_WR=1, MAX_WR_OUT=2: 3 back-to-back writes, B stalled -> third held hready=0 until first B.
//    Then read blocked until count=0.
//  5 POSTED_WR=1: bresp=SLVERR -> wr_err=1 sticky; wr_err_clr with coincident error B -> stays 1.
//  6 areset asserted during WR with awvalid=1 -> next cycle awvalid=wvalid=0, hready=1, count=0.

Source files
------------

// File: rtl/ahbl2axi4l_pkg.sv
// Shared constants for the AHB-Lite to AXI4-Lite bridge.
package ahbl2axi4l_pkg;

  // Bridge FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WR    = 3'd1;
  localparam state_t S_WRESP = 3'd2;
  localparam state_t S_RD    = 3'd3;
  localparam state_t S_ERR1  = 3'd4;
  localparam state_t S_ERR2  = 3'd5;

  // AHB transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // SLVERR and DECERR both map to an AHB ERROR; EXOKAY is plain OKAY
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/ahbl2axi4l_p_strb_gen.sv
// Byte-lane strobe generator: hsize + address LSBs -> write strobe.
// An hsize wider than the bus drives every lane.
module ahbl_strb_gen #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                     hsize,
  input  logic [$clog2(DATA_W/8)-1:0]    addr_lsb,
  output logic [DATA_W/8-1:0]            wstrb
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic       illegal;
  logic [4:0] lo;
  logic [4:0] hi;

  assign illegal = (hsize > 3'(OFF_W));
  assign lo      = 5'(addr_lsb);
  assign hi      = lo + (5'd1 << hsize);

  // A lane is on when it falls inside [offset, offset + 2^hsize)
  for (genvar i = 0; i < STRB_W; i++) begin : g_lane
    assign wstrb[i] = illegal | ((5'(i) >= lo) && (5'(i) < hi));
  end

endmodule

// File: rtl/ahbl2axi4l_p.sv
// AHB-Lite slave to AXI4-Lite master bridge with optional posted writes.
module ahbl2axi4l_p
  import ahbl2axi4l_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int POSTED_WR  = 0,
  parameter int MAX_WR_OUT = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  // AHB-Lite slave
  input  logic                  ahb_hsel,
  input  logic                  ahb_hreadyin,
  input  logic [ADDR_W-1:0]     ahb_haddr,
  input  logic [2:0]            ahb_hsize,
  input  logic [1:0]            ahb_htrans,
  input  logic                  ahb_hwrite,
  input  logic [DATA_W-1:0]     ahb_hwdata,
  output logic [DATA_W-1:0]     ahb_hrdata,
  output logic                  ahb_hready,
  output logic                  ahb_hresp,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  // Posted-write error reporting
  output logic                  wr_err,
  input  logic                  wr_err_clr
);

  localparam int         STRB_W  = DATA_W / 8;
  localparam int         OFF_W   = $clog2(STRB_W);
  localparam logic       PWR     = (POSTED_WR != 0);
  localparam logic [3:0] MAX_CNT = 4'(MAX_WR_OUT);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_dw
    $error("ahbl2axi4l_p: DATA_W must be 32 or 64");
  end
  if (POSTED_WR != 0 && (MAX_WR_OUT < 1 || MAX_WR_OUT > 15)) begin : g_bad_max
    $error("ahbl2axi4l_p: MAX_WR_OUT must be 1..15");
  end

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [STRB_W-1:0]   strb_n;
  logic                aw_done, w_done, ar_done;
  logic [3:0]          cnt;
  logic                accept;
  logic                aw_hs, w_hs, b_hs, ar_hs;
  logic                wr_last;
  logic                issue_ok;
  logic                unused_resp;

  assign unused_resp = ^{axi_bresp[0], axi_rresp[0]};

  ahbl_strb_gen #(.DATA_W(DATA_W)) u_strb (
    .hsize    (ahb_hsize),
    .addr_lsb (ahb_haddr[OFF_W-1:0]),
    .wstrb    (strb_n)
  );

  // Address phase is taken whenever we are showing hready=1 to a selected NONSEQ/SEQ
  assign accept = ahb_hsel & ahb_hreadyin & ahb_htrans[1] & ahb_hready;

  // Posted mode holds a new write off the bus while the B window is full
  assign issue_ok = !PWR || (cnt < MAX_CNT);

  assign axi_awaddr  = addr_q;
  assign axi_araddr  = addr_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wdata   = ahb_hwdata;
  assign axi_awvalid = (state == S_WR) && !aw_done && issue_ok;
  assign axi_wvalid  = (state == S_WR) && !w_done && issue_ok;
  assign axi_bready  = PWR ? (cnt != 4'd0) : (state == S_WRESP);
  assign axi_arvalid = (state == S_RD) && !ar_done && (!PWR || cnt == 4'd0);
  assign axi_rready  = (state == S_RD);
  assign ahb_hrdata  = axi_rdata;
  assign ahb_hresp   = (state == S_ERR1) || (state == S_ERR2);

  assign aw_hs   = axi_awvalid & axi_awready;
  assign w_hs    = axi_wvalid & axi_wready;
  assign b_hs    = axi_bvalid & axi_bready;
  assign ar_hs   = axi_arvalid & axi_arready;
  assign wr_last = (state == S_WR) && (aw_done | aw_hs) && (w_done | w_hs);

  // HREADYOUT: high in idle/ERR2 and in the cycle a transfer completes OKAY
  always_comb begin
    ahb_hready = 1'b0;
    case (state)
      S_IDLE:  ahb_hready = 1'b1;
      S_WR:    ahb_hready = PWR && wr_last;
      S_WRESP: ahb_hready = axi_bvalid && !resp_is_err(axi_bresp);
      S_RD:    ahb_hready = axi_rvalid && !resp_is_err(axi_rresp);
      S_ERR1:  ahb_hready = 1'b0;
      S_ERR2:  ahb_hready = 1'b1;
      default: ahb_hready = 1'b1;
    endcase
  end

  // Next state; an accepted address phase overrides the completion target
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = S_IDLE;
      S_WR:    if (wr_last) state_n = PWR ? S_IDLE : S_WRESP;
      S_WRESP: if (axi_bvalid) state_n = resp_is_err(axi_bresp) ? S_ERR1 : S_IDLE;
      S_RD:    if (axi_rvalid) state_n = resp_is_err(axi_rresp) ? S_ERR1 : S_IDLE;
      S_ERR1:  state_n = S_ERR2;
      S_ERR2:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (accept) state_n = ahb_hwrite ? S_WR : S_RD;
  end

  // FSM state, latched address phase and per-channel handshake flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= ahb_haddr;
        wstrb_q <= strb_n;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        ar_done <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
        if (ar_hs) ar_done <= 1'b1;
      end
    end
  end

  // Writes issued but not yet answered by B; only moves in posted mode
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt <= 4'd0;
    end else begin
      if (PWR && wr_last && !b_hs)      cnt <= cnt + 4'd1;
      else if (PWR && b_hs && !wr_last) cnt <= cnt - 4'd1;
    end
  end

  // Sticky posted-write error; a new error beats a same-cycle clear
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= (PWR && b_hs && resp_is_err(axi_bresp)) || (wr_err && !wr_err_clr);
    end
  end

endmodule
